cs_init_event_sender: RTL and testbench

Initiator-side counterpart of the target event interface: on every rising edge of mission clock `clk_0_h` it snapshots the initiator's per-channel `{wen, data}` vectors and streams them, one channel per handshake, toward the target link. It holds the mission clock frozen until the target's `{valid, o_data}` response vector returns, then presents that vector registered to initiator logic. It sits between the initiator partition and the TCP/DPI fringe adapter, and replaces per-event behavioural code with synthesizable RTL.

---
 rtl/cs_init_event_sender.sv | 201 ++++++++++++++++++++
 tb/tb_cs_init_event_sender.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cs_init_event_sender.sv
// Initiator-side event sender: snapshots per-channel {wen, data} on each mission clock edge,
// streams one channel per handshake, and freezes the mission clock until the response returns.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | waiting for a mission clock rising edge
// S_SEND     | presenting snapshot[ch_idx] to the fringe, one channel per handshake
// S_WAIT_RSP | all channels sent, mission clock frozen, watchdog running
// S_ERROR    | watchdog expired; terminal until reset, mission clock stays frozen
module cs_init_event_sender #(
    parameter int N_CH     = 3,
    parameter int DATA_W   = 8,
    parameter int WDOG_MAX = 10000,
    parameter int WDOG_W   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clk_0_h,
    input  logic [N_CH-1:0]        ch_wen_i,
    input  logic [N_CH*DATA_W-1:0] ch_data_i,
    output logic                   freeze_clk_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    output logic [1:0]             tx_index_o,
    output logic [DATA_W:0]        tx_payload_o,
    input  logic                   rx_valid_i,
    input  logic [DATA_W:0]        rx_payload_i,
    output logic                   valid_o,
    output logic [DATA_W-1:0]      o_data_o,
    output logic                   rsp_strobe_o,
    output logic                   wdog_err_o,
    output logic                   overrun_o,
    output logic                   busy_o
);

    localparam int                PW       = DATA_W + 1;
    localparam logic [1:0]        LAST_IDX = 2'(N_CH - 1);
    localparam logic [WDOG_W-1:0] WDOG_TC  = WDOG_W'(WDOG_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEND     = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_ERROR    = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic                       r_s1;
    logic                       r_s2;
    logic                       r_s3;
    logic                       w_evt;

    logic [N_CH-1:0][PW-1:0]    r_snap;
    logic [1:0]                 r_ch_idx;
    logic [WDOG_W-1:0]          r_wdog;
    logic                       r_freeze;
    logic                       r_valid;
    logic [DATA_W-1:0]          r_o_data;
    logic                       r_strobe;
    logic                       r_wdog_err;
    logic                       r_overrun;

    logic                       w_capture;
    logic                       w_send_hs;
    logic                       w_last_hs;
    logic                       w_rsp_take;
    logic                       w_wdog_tc;
    logic                       w_in_send;

    // clk_0_h is asynchronous: two flops for metastability, a third for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= clk_0_h;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_evt = r_s2 & ~r_s3;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_send_hs   = 1'b0;
        w_last_hs   = 1'b0;
        w_rsp_take  = 1'b0;
        w_wdog_tc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_evt) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_ready_i) begin
                    w_send_hs = 1'b1;
                    if (r_ch_idx == LAST_IDX) begin
                        w_last_hs   = 1'b1;
                        w_state_nxt = S_WAIT_RSP;
                    end
                end
            end
            S_WAIT_RSP: begin
                // A response landing on the terminal count takes priority over the error.
                if (rx_valid_i) begin
                    w_rsp_take  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_wdog == WDOG_TC) begin
                    w_wdog_tc   = 1'b1;
                    w_state_nxt = S_ERROR;
                end
            end
            S_ERROR: begin
                w_state_nxt = S_ERROR;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_snap   <= '0;
            r_ch_idx <= 2'd0;
        end else if (w_capture) begin
            for (int k = 0; k < N_CH; k++) begin
                r_snap[k] <= {ch_wen_i[k], ch_data_i[k*DATA_W +: DATA_W]};
            end
            r_ch_idx <= 2'd0;
        end else if (w_send_hs && !w_last_hs) begin
            r_ch_idx <= r_ch_idx + 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wdog <= '0;
        end else if (w_last_hs) begin
            r_wdog <= '0;
        end else if (r_state == S_WAIT_RSP) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_freeze   <= 1'b0;
            r_valid    <= 1'b0;
            r_o_data   <= '0;
            r_strobe   <= 1'b0;
            r_wdog_err <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_strobe <= w_rsp_take;
            if (w_capture) begin
                r_freeze <= 1'b1;
            end else if (w_rsp_take) begin
                r_freeze <= 1'b0;
            end
            if (w_rsp_take) begin
                r_valid  <= rx_payload_i[DATA_W];
                r_o_data <= rx_payload_i[DATA_W-1:0];
            end
            if (w_wdog_tc) begin
                r_wdog_err <= 1'b1;
            end
            if (w_evt && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign w_in_send    = (r_state == S_SEND);
    assign tx_valid_o   = w_in_send;
    assign tx_index_o   = w_in_send ? r_ch_idx : 2'd0;
    assign tx_payload_o = w_in_send ? r_snap[r_ch_idx] : '0;
    assign freeze_clk_o = r_freeze;
    assign valid_o      = r_valid;
    assign o_data_o     = r_o_data;
    assign rsp_strobe_o = r_strobe;
    assign wdog_err_o   = r_wdog_err;
    assign overrun_o    = r_overrun;
    assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_cs_init_event_sender.sv
// Directed bench for cs_init_event_sender: a table of full transactions plus hand-written
// sequences for backpressure, snapshot isolation, overrun, watchdog and mid-transfer reset.
module tb_cs_init_event_sender;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clk_0_h;
    logic [2:0]  ch_wen_i;
    logic [23:0] ch_data_i;
    logic        freeze_clk_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [1:0]  tx_index_o;
    logic [8:0]  tx_payload_o;
    logic        rx_valid_i;
    logic [8:0]  rx_payload_i;
    logic        valid_o;
    logic [7:0]  o_data_o;
    logic        rsp_strobe_o;
    logic        wdog_err_o;
    logic        overrun_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_mis = 0;
    int hs_cnt = 0;
    logic [1:0] hs_idx_q[$];

    cs_init_event_sender #(
        .N_CH(3), .DATA_W(8), .WDOG_MAX(20), .WDOG_W(16)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clk_0_h(clk_0_h),
        .ch_wen_i(ch_wen_i), .ch_data_i(ch_data_i),
        .freeze_clk_o(freeze_clk_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .tx_index_o(tx_index_o), .tx_payload_o(tx_payload_o),
        .rx_valid_i(rx_valid_i), .rx_payload_i(rx_payload_i),
        .valid_o(valid_o), .o_data_o(o_data_o), .rsp_strobe_o(rsp_strobe_o),
        .wdog_err_o(wdog_err_o), .overrun_o(overrun_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Handshake log, sampled mid-low-phase so it never races the stimulus driven on negedge.
    always @(negedge clk_i) begin
        #1;
        if (!rst_i && tx_valid_o && tx_ready_i) begin
            hs_cnt++;
            hs_idx_q.push_back(tx_index_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [2:0]       wen;
        logic [23:0]      data;
        logic [8:0]       rsp;
        logic [2:0][8:0]  exp_pl;
        logic             exp_valid;
        logic [7:0]       exp_odata;
    } vec_t;

    vec_t vecs[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " freeze"},   32'(freeze_clk_o), 32'd0);
        chk({tag, " tx_valid"}, 32'(tx_valid_o),   32'd0);
        chk({tag, " tx_index"}, 32'(tx_index_o),   32'd0);
        chk({tag, " tx_pl"},    32'(tx_payload_o), 32'd0);
        chk({tag, " valid_o"},  32'(valid_o),      32'd0);
        chk({tag, " o_data"},   32'(o_data_o),     32'd0);
        chk({tag, " strobe"},   32'(rsp_strobe_o), 32'd0);
        chk({tag, " wdog_err"}, 32'(wdog_err_o),   32'd0);
        chk({tag, " overrun"},  32'(overrun_o),    32'd0);
        chk({tag, " busy"},     32'(busy_o),       32'd0);
    endtask

    // Returns at the negedge after the capture edge (edge 2), with index 0 on the bus.
    task automatic event_start(input logic [2:0] wen, input logic [23:0] data);
        @(negedge clk_i);
        ch_wen_i  = wen;
        ch_data_i = data;
        clk_0_h   = 1'b1;
        hs_cnt    = 0;
        hs_idx_q.delete();
        @(negedge clk_i);
        @(negedge clk_i);
        chk("busy before capture", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        clk_0_h = 1'b0;
        chk("busy at capture",     32'(busy_o),       32'd1);
        chk("freeze at capture",   32'(freeze_clk_o), 32'd1);
        chk("tx_valid at capture", 32'(tx_valid_o),   32'd1);
    endtask

    task automatic xfer_check(input logic [2:0][8:0] exp_pl);
        tx_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("tx_valid k%0d", k), 32'(tx_valid_o),   32'd1);
            chk($sformatf("tx_index k%0d", k), 32'(tx_index_o),   32'(k));
            chk($sformatf("tx_pl k%0d", k),    32'(tx_payload_o), 32'(exp_pl[k]));
            @(negedge clk_i);
        end
        chk("tx_valid in wait", 32'(tx_valid_o), 32'd0);
        chk("busy in wait",     32'(busy_o),     32'd1);
    endtask

    task automatic respond(input logic [8:0] rsp, input logic ev, input logic [7:0] ed);
        rx_valid_i   = 1'b1;
        rx_payload_i = rsp;
        @(negedge clk_i);
        rx_valid_i   = 1'b0;
        rx_payload_i = 9'h0;
        chk("rsp valid_o", 32'(valid_o),      32'(ev));
        chk("rsp o_data",  32'(o_data_o),     32'(ed));
        chk("rsp strobe",  32'(rsp_strobe_o), 32'd1);
        chk("rsp freeze",  32'(freeze_clk_o), 32'd0);
        chk("rsp busy",    32'(busy_o),       32'd0);
        @(negedge clk_i);
        chk("strobe one cycle", 32'(rsp_strobe_o), 32'd0);
    endtask

    task automatic chk_hs_seq(input string tag);
        chk({tag, " hs count"}, 32'(hs_cnt), 32'd3);
        if (hs_idx_q.size() == 3) begin
            for (int k = 0; k < 3; k++)
                chk($sformatf("%s hs idx%0d", tag, k), 32'(hs_idx_q[k]), 32'(k));
        end
    endtask

    initial begin
        logic [8:0] held;
        vecs[0] = '{wen: 3'b101, data: {8'hFF, 8'h3C, 8'hA5}, rsp: 9'h142,
                    exp_pl: {9'h1FF, 9'h03C, 9'h1A5}, exp_valid: 1'b1, exp_odata: 8'h42};
        vecs[1] = '{wen: 3'b010, data: {8'h00, 8'h81, 8'h7E}, rsp: 9'h0C3,
                    exp_pl: {9'h000, 9'h181, 9'h07E}, exp_valid: 1'b0, exp_odata: 8'hC3};
        vecs[2] = '{wen: 3'b111, data: {8'h12, 8'h34, 8'h56}, rsp: 9'h1FF,
                    exp_pl: {9'h112, 9'h134, 9'h156}, exp_valid: 1'b1, exp_odata: 8'hFF};

        rst_i = 1'b1; clk_0_h = 1'b0; ch_wen_i = '0; ch_data_i = '0;
        tx_ready_i = 1'b1; rx_valid_i = 1'b0; rx_payload_i = '0;
        repeat (3) @(negedge clk_i);
        chk_reset_outputs("reset");
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // Table of complete transactions with the fringe always ready.
        for (int v = 0; v < 3; v++) begin
            event_start(vecs[v].wen, vecs[v].data);
            xfer_check(vecs[v].exp_pl);
            chk_hs_seq($sformatf("vec%0d", v));
            respond(vecs[v].rsp, vecs[v].exp_valid, vecs[v].exp_odata);
        end
        chk("no overrun so far", 32'(overrun_o), 32'd0);

        // Backpressure on index 1 for five cycles.
        event_start(3'b011, {8'h11, 8'h22, 8'h33});
        chk("bp idx0", 32'(tx_index_o), 32'd0);
        @(negedge clk_i);
        tx_ready_i = 1'b0;
        held = tx_payload_o;
        chk("bp held pl value", 32'(held), 32'h122);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp valid c%0d", i), 32'(tx_valid_o),   32'd1);
            chk($sformatf("bp idx c%0d", i),   32'(tx_index_o),   32'd1);
            chk($sformatf("bp pl c%0d", i),    32'(tx_payload_o), 32'h122);
            @(negedge clk_i);
        end
        chk("bp idx after stall", 32'(tx_index_o), 32'd1);
        tx_ready_i = 1'b1;
        @(negedge clk_i);
        chk("bp idx2",    32'(tx_index_o),   32'd2);
        chk("bp pl2",     32'(tx_payload_o), 32'h011);
        @(negedge clk_i);
        chk("bp in wait", 32'(tx_valid_o),   32'd0);
        chk_hs_seq("bp");
        respond(9'h100, 1'b1, 8'h00);

        // Inputs change right after the capture edge; payloads must come from the snapshot.
        event_start(3'b110, {8'hC0, 8'hDE, 8'hAD});
        ch_wen_i  = 3'b001;
        ch_data_i = {8'h99, 8'h88, 8'h77};
        xfer_check({9'h1C0, 9'h1DE, 9'h0AD});
        respond(9'h055, 1'b0, 8'h55);

        // Second mission edge while waiting for the response.
        event_start(3'b000, {8'h03, 8'h02, 8'h01});
        xfer_check({9'h003, 9'h002, 9'h001});
        clk_0_h = 1'b1;
        repeat (3) @(negedge clk_i);
        clk_0_h = 1'b0;
        chk("overrun set",       32'(overrun_o),  32'd1);
        chk("overrun busy",      32'(busy_o),     32'd1);
        chk("overrun no resend", 32'(tx_valid_o), 32'd0);
        respond(9'h1EE, 1'b1, 8'hEE);
        repeat (3) @(negedge clk_i);
        chk("overrun sticky",    32'(overrun_o), 32'd1);
        chk("overrun idle",      32'(busy_o),    32'd0);
        chk_hs_seq("overrun");

        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Response exactly on the watchdog terminal cycle wins.
        event_start(3'b001, {8'h00, 8'h00, 8'h5A});
        xfer_check({9'h000, 9'h000, 9'h15A});
        repeat (19) @(negedge clk_i);
        chk("tc pre err", 32'(wdog_err_o), 32'd0);
        respond(9'h1A1, 1'b1, 8'hA1);
        chk("tc err clear", 32'(wdog_err_o), 32'd0);

        // No response: error exactly WDOG_MAX cycles after entering WAIT_RSP.
        event_start(3'b001, {8'h00, 8'h00, 8'h6B});
        xfer_check({9'h000, 9'h000, 9'h16B});
        repeat (19) @(negedge clk_i);
        chk("wdog not yet", 32'(wdog_err_o), 32'd0);
        @(negedge clk_i);
        chk("wdog err",     32'(wdog_err_o),   32'd1);
        chk("wdog freeze",  32'(freeze_clk_o), 32'd1);
        chk("wdog busy",    32'(busy_o),       32'd1);
        chk("wdog txv",     32'(tx_valid_o),   32'd0);
        rx_valid_i   = 1'b1;
        rx_payload_i = 9'h0AA;
        @(negedge clk_i);
        rx_valid_i   = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("err ignores rsp", 32'(rsp_strobe_o), 32'd0);
        chk("err keeps data",  32'(o_data_o),     32'hA1);
        chk("err freeze held", 32'(freeze_clk_o), 32'd1);
        chk("err busy held",   32'(busy_o),       32'd1);

        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("err cleared by reset", 32'(wdog_err_o), 32'd0);

        // Asynchronous reset in SEND after index 0 is transferred.
        event_start(3'b111, {8'h01, 8'h02, 8'h03});
        @(negedge clk_i);
        chk("pre-rst idx1", 32'(tx_index_o), 32'd1);
        rst_i = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("post-rst idle", 32'(busy_o), 32'd0);
        event_start(3'b000, {8'h0C, 8'h0B, 8'h0A});
        xfer_check({9'h00C, 9'h00B, 9'h00A});
        chk_hs_seq("restart");
        respond(9'h177, 1'b1, 8'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
